// File: rtl/stc0_pkg.sv
// Shared widths and helpers for the stc0 egress packer.
package stc0_pkg;

  localparam int unsigned STC0_BYTE_W         = 8;
  localparam int unsigned STC0_WORD_W         = 32;
  localparam int unsigned STC0_BYTES_PER_WORD = 4;
  localparam int unsigned STC0_IDX_W          = $clog2(STC0_BYTES_PER_WORD);
  localparam int unsigned STC0_PART_W         = STC0_WORD_W - STC0_BYTE_W;
  localparam int unsigned STC0_DROP_CNT_W     = 8;

  // Saturating increment for the dropped-word counter.
  function automatic logic [STC0_DROP_CNT_W-1:0] sat_inc(
    input logic [STC0_DROP_CNT_W-1:0] v
  );
    return (&v) ? v : v + STC0_DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/stc0_egress_packer_if.sv
// Egress byte stream in, packed word FIFO out, plus overflow status.
interface stc0_egress_packer_if #(
  parameter int unsigned DEPTH = 8
);
  import stc0_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);

  logic [STC0_BYTE_W-1:0]     ED;
  logic                       EValid;
  logic                       Flush;
  logic                       Pop;
  logic                       ClrOverflow;
  logic [STC0_WORD_W-1:0]     WordOut;
  logic                       WordValid;
  logic [AW:0]                Level;
  logic                       Overflow;
  logic [STC0_DROP_CNT_W-1:0] DropCnt;

  // Driver side: core egress plus the word reader.
  modport master (
    output ED, EValid, Flush, Pop, ClrOverflow,
    input  WordOut, WordValid, Level, Overflow, DropCnt
  );

  // Packer side.
  modport slave (
    input  ED, EValid, Flush, Pop, ClrOverflow,
    output WordOut, WordValid, Level, Overflow, DropCnt
  );

endinterface

// File: rtl/stc0_sync_fifo.sv
// Flop-based first-word-fall-through FIFO. Push while full is accepted only alongside a
// pop. The output word is registered and holds its last value once the FIFO drains.
module stc0_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = out_q;

  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);

  // Pointer/count update and next head word.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = wdata_i;
        wr_d        = wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_d = rd_q + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    // Present the new head; hold the old word when empty.
    out_d = (cnt_d != '0) ? mem_d[rd_d] : out_q;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

endmodule

// File: rtl/stc0_egress_packer.sv
// Packs the core egress byte stream into 32-bit words (first byte in the low lane) and
// queues them for a word-wide reader; counts words lost to a full FIFO.
module stc0_egress_packer
  import stc0_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input logic                   Clk,
  input logic                   ARstb,
  stc0_egress_packer_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [STC0_IDX_W-1:0]      idx_q, idx_d;
  logic [STC0_PART_W-1:0]     part_q, part_d;
  logic                       ovf_q, ovf_d;
  logic [STC0_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic                   word_done;
  logic [STC0_WORD_W-1:0] word;
  logic                   fifo_full, fifo_empty;
  logic                   pop_ok;
  logic                   drop;
  logic [AW:0]            level;

  // A byte landing in the Flush cycle is discarded, so it never completes a word.
  assign word_done = bus.EValid & ~bus.Flush & (idx_q == STC0_IDX_W'(STC0_BYTES_PER_WORD - 1));
  assign word      = {bus.ED, part_q};
  assign pop_ok    = bus.Pop & ~fifo_empty & ~bus.Flush;
  assign drop      = word_done & fifo_full & ~pop_ok;

  // Byte lane index and partial word; EValid holes leave both untouched.
  always_comb begin
    idx_d  = idx_q;
    part_d = part_q;
    if (bus.Flush) begin
      idx_d  = '0;
      part_d = '0;
    end else if (bus.EValid) begin
      idx_d = idx_q + STC0_IDX_W'(1);
      unique case (idx_q)
        2'd0:    part_d[7:0]   = bus.ED;
        2'd1:    part_d[15:8]  = bus.ED;
        2'd2:    part_d[23:16] = bus.ED;
        default: part_d        = part_q;
      endcase
    end
  end

  // Sticky overflow and saturating drop count; a drop beats a same-cycle clear.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = bus.ClrOverflow ? STC0_DROP_CNT_W'(1) : sat_inc(drop_cnt_q);
    end else if (bus.ClrOverflow) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge ARstb) begin
    if (!ARstb) begin
      idx_q      <= '0;
      part_q     <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      idx_q      <= idx_d;
      part_q     <= part_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  stc0_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (STC0_WORD_W)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (ARstb),
    .flush_i (bus.Flush),
    .push_i  (word_done),
    .pop_i   (bus.Pop),
    .wdata_i (word),
    .rdata_o (bus.WordOut),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign bus.WordValid = ~fifo_empty;
  assign bus.Level     = level;
  assign bus.Overflow  = ovf_q;
  assign bus.DropCnt   = drop_cnt_q;

endmodule
